typec_tx_sched: RTL and testbench

TYPEC_TX_SCHED -- requirements
Module: typec_tx_sched

---
 rtl/typec_pkg.sv | 64 ++++++
 rtl/typec_prio_arb.sv | 18 +
 rtl/typec_tx_sched.sv | 183 ++++++++++++++++++
 tb/tb_typec_tx_sched.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/typec_pkg.sv
// Shared encodings for the Type-C transmit scheduler: btype codes, request type
// encodings and the scheduler state encoding.
package typec_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StStart = 3'd2,
    StBusy  = 3'd3,
    StRel   = 3'd4,
    StGap   = 3'd5
  } sched_state_e;

  typedef enum logic [1:0] {
    HsIllegal = 2'd0,
    HsAck     = 2'd1,
    HsNak     = 2'd2,
    HsStall   = 2'd3
  } hs_type_e;

  typedef enum logic [1:0] {
    StsDlink   = 2'd0,
    StsDtype   = 2'd1,
    StsDtemp   = 2'd2,
    StsIllegal = 2'd3
  } st_type_e;

  localparam logic [3:0] BtAck   = 4'b0001;
  localparam logic [3:0] BtNak   = 4'b0010;
  localparam logic [3:0] BtStall = 4'b0011;
  localparam logic [3:0] BtDlink = 4'b1000;
  localparam logic [3:0] BtDtype = 4'b1001;
  localparam logic [3:0] BtDtemp = 4'b1010;
  localparam logic [3:0] BtData0 = 4'b1101;
  localparam logic [3:0] BtData1 = 4'b1110;

  // Grant bit positions, highest priority first.
  localparam int unsigned GntHs = 0;
  localparam int unsigned GntSt = 1;
  localparam int unsigned GntDt = 2;

  function automatic logic [3:0] hs_btype(input logic [1:0] t);
    logic [3:0] bt;
    case (t)
      HsAck:   bt = BtAck;
      HsNak:   bt = BtNak;
      HsStall: bt = BtStall;
      default: bt = 4'b0000;
    endcase
    return bt;
  endfunction

  function automatic logic [3:0] st_btype(input logic [1:0] t);
    logic [3:0] bt;
    case (t)
      StsDlink: bt = BtDlink;
      StsDtype: bt = BtDtype;
      StsDtemp: bt = BtDtemp;
      default:  bt = 4'b0000;
    endcase
    return bt;
  endfunction

endpackage

// File: rtl/typec_prio_arb.sv
// Three-way fixed-priority arbiter; bit 0 wins over bit 1, which wins over bit 2.
module typec_prio_arb (
  input  logic [2:0] req_i,
  output logic [2:0] gnt_o
);

  always_comb begin
    gnt_o = 3'b000;
    if (req_i[0]) begin
      gnt_o[0] = 1'b1;
    end else if (req_i[1]) begin
      gnt_o[1] = 1'b1;
    end else if (req_i[2]) begin
      gnt_o[2] = 1'b1;
    end
  end

endmodule

// File: rtl/typec_tx_sched.sv
// Type-C transmit scheduler: arbitrates handshake/status/data requests and sequences the
// transmitter. Optional BUSY watchdog enabled by defining TYPEC_TX_SCHED_TIMEOUT_EN.
module typec_tx_sched
  import typec_pkg::*;
#(
  parameter int unsigned IPG         = 4,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs_req_i,
  input  logic [1:0]  hs_type_i,
  input  logic        st_req_i,
  input  logic [1:0]  st_type_i,
  input  logic        dt_req_i,
  input  logic [11:0] dt_addr_i,
  input  logic [11:0] dt_len_i,
  input  logic        dt_retry_i,
  input  logic        tog_clr_i,
  input  logic        fd_i,
  output logic        hs_done_o,
  output logic        st_done_o,
  output logic        dt_done_o,
  output logic        err_o,
  output logic        fs_o,
  output logic [3:0]  btype_o,
  output logic [11:0] tx_addr_o,
  output logic [11:0] tx_len_o,
  output logic        busy_o
);

  localparam int unsigned GapW = (IPG > 1) ? $clog2(IPG) : 1;
  localparam logic [GapW-1:0] GapInit = GapW'(IPG - 1);
  localparam sched_state_e AfterPkt = (IPG == 0) ? StIdle : StGap;

  sched_state_e    state_q;
  logic [2:0]      gnt_q;
  logic [3:0]      btype_q;
  logic [11:0]     tx_addr_q, tx_len_q;
  logic            fs_q, err_q, tog_q, retry_q;
  logic            hs_done_q, st_done_q, dt_done_q;
  logic [GapW-1:0] gap_q;

  logic [2:0] gnt;
  logic       load_reject;
  logic [3:0] load_btype;

  typec_prio_arb u_arb (
    .req_i ({dt_req_i, st_req_i, hs_req_i}),
    .gnt_o (gnt)
  );

  // Winner decode in LOAD; a retry resends with the opposite of the current toggle.
  always_comb begin
    load_reject = 1'b0;
    load_btype  = 4'b0000;
    if (gnt_q[GntHs]) begin
      load_reject = (hs_type_i == HsIllegal);
      load_btype  = hs_btype(hs_type_i);
    end else if (gnt_q[GntSt]) begin
      load_reject = (st_type_i == StsIllegal);
      load_btype  = st_btype(st_type_i);
    end else begin
      load_reject = (dt_len_i == 12'd0);
      load_btype  = ((dt_retry_i ? ~tog_q : tog_q) == 1'b1) ? BtData1 : BtData0;
    end
  end

`ifdef TYPEC_TX_SCHED_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TmoW-1:0] tmo_q;
  logic            tmo_hit;
  assign tmo_hit = (tmo_q == TmoW'(TIMEOUT_CYC - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      gnt_q     <= 3'b000;
      btype_q   <= 4'b0000;
      tx_addr_q <= 12'd0;
      tx_len_q  <= 12'd0;
      fs_q      <= 1'b0;
      err_q     <= 1'b0;
      tog_q     <= 1'b0;
      retry_q   <= 1'b0;
      hs_done_q <= 1'b0;
      st_done_q <= 1'b0;
      dt_done_q <= 1'b0;
      gap_q     <= '0;
`ifdef TYPEC_TX_SCHED_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      hs_done_q <= 1'b0;
      st_done_q <= 1'b0;
      dt_done_q <= 1'b0;
      err_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|gnt) begin
            gnt_q   <= gnt;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          btype_q <= load_btype;
          if (gnt_q[GntDt]) begin
            tx_addr_q <= dt_addr_i;
            tx_len_q  <= dt_len_i;
            retry_q   <= dt_retry_i;
          end
          if (load_reject) begin
            err_q                               <= 1'b1;
            {dt_done_q, st_done_q, hs_done_q}   <= gnt_q;
            gap_q                               <= GapInit;
            state_q                             <= AfterPkt;
          end else begin
            state_q <= StStart;
          end
        end
        StStart: begin
          fs_q    <= 1'b1;
          state_q <= StBusy;
`ifdef TYPEC_TX_SCHED_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end
        StBusy: begin
          if (fd_i) begin
            fs_q                              <= 1'b0;
            {dt_done_q, st_done_q, hs_done_q} <= gnt_q;
            if (gnt_q[GntDt] && !retry_q) begin
              tog_q <= ~tog_q;
            end
            state_q <= StRel;
`ifdef TYPEC_TX_SCHED_TIMEOUT_EN
          end else if (tmo_hit) begin
            fs_q                              <= 1'b0;
            err_q                             <= 1'b1;
            {dt_done_q, st_done_q, hs_done_q} <= gnt_q;
            state_q                           <= StRel;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
`endif
          end
        end
        StRel: begin
          if (!fd_i) begin
            gap_q   <= GapInit;
            state_q <= AfterPkt;
          end
        end
        StGap: begin
          if (gap_q == '0) begin
            state_q <= StIdle;
          end else begin
            gap_q <= gap_q - GapW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
      // A clear wins over any flip applied above in the same cycle.
      if (tog_clr_i) begin
        tog_q <= 1'b0;
      end
    end
  end

  assign hs_done_o = hs_done_q;
  assign st_done_o = st_done_q;
  assign dt_done_o = dt_done_q;
  assign err_o     = err_q;
  assign fs_o      = fs_q;
  assign btype_o   = btype_q;
  assign tx_addr_o = tx_addr_q;
  assign tx_len_o  = tx_len_q;
  assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_typec_tx_sched.sv
// Directed self-checking bench for typec_tx_sched (IPG=4); the watchdog case runs only
// when TYPEC_TX_SCHED_TIMEOUT_EN is defined.
module tb_typec_tx_sched;

  localparam int unsigned IPG = 4;
`ifdef TYPEC_TX_SCHED_TIMEOUT_EN
  localparam int unsigned TMO = 8;
`else
  localparam int unsigned TMO = 1023;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        hs_req, st_req, dt_req, dt_retry, tog_clr, fd;
  logic [1:0]  hs_type, st_type;
  logic [11:0] dt_addr, dt_len;
  logic        hs_done, st_done, dt_done, err, fs, busy;
  logic [3:0]  btype;
  logic [11:0] tx_addr, tx_len;
  logic [2:0]  done_vec;

  assign done_vec = {dt_done, st_done, hs_done};

  int checks = 0;
  int failures = 0;
  int n_fs = 0;
  int n_dt = 0;
  int snap_fs, snap_dt, n;
  logic fs_prev = 1'b0;

  always #5 clk = ~clk;

  typec_tx_sched #(
    .IPG         (IPG),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hs_req_i   (hs_req),
    .hs_type_i  (hs_type),
    .st_req_i   (st_req),
    .st_type_i  (st_type),
    .dt_req_i   (dt_req),
    .dt_addr_i  (dt_addr),
    .dt_len_i   (dt_len),
    .dt_retry_i (dt_retry),
    .tog_clr_i  (tog_clr),
    .fd_i       (fd),
    .hs_done_o  (hs_done),
    .st_done_o  (st_done),
    .dt_done_o  (dt_done),
    .err_o      (err),
    .fs_o       (fs),
    .btype_o    (btype),
    .tx_addr_o  (tx_addr),
    .tx_len_o   (tx_len),
    .busy_o     (busy)
  );

  always @(negedge clk) begin
    if (fs === 1'b1 && fs_prev !== 1'b1) n_fs++;
    if (dt_done === 1'b1) n_dt++;
    fs_prev = fs;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ticks until fs is seen high (bounded) and checks the latency.
  task automatic wait_fs(input string tag, input int exp_lat);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (fs !== 1'b1 && k < 40);
    chk({tag, "_lat"}, k, exp_lat);
  endtask

  task automatic drop_req(input int idx);
    case (idx)
      0:       hs_req = 1'b0;
      1:       st_req = 1'b0;
      default: dt_req = 1'b0;
    endcase
  endtask

  // One full packet: wait for fs, check type, return fd after fd_dly cycles, check done.
  task automatic serve(input string tag, input int idx, input logic [3:0] exp_bt,
                       input int fd_dly, input int exp_lat, input bit clr);
    logic [2:0] ev;
    ev = 3'b000;
    ev[idx] = 1'b1;
    wait_fs(tag, exp_lat);
    chk({tag, "_btype"}, btype, exp_bt);
    if (idx == 2) begin
      chk({tag, "_addr"}, tx_addr, dt_addr);
      chk({tag, "_len"}, tx_len, dt_len);
    end
    repeat (fd_dly - 1) tick();
    fd = 1'b1;
    tog_clr = clr;
    tick();
    chk({tag, "_fs_drop"}, fs, 1'b0);
    chk({tag, "_done"}, done_vec, ev);
    fd = 1'b0;
    tog_clr = 1'b0;
    drop_req(idx);
    tick();
    chk({tag, "_done_once"}, done_vec, 3'b000);
  endtask

  // From one cycle into GAP, IPG more cycles return to IDLE.
  task automatic drain(input string tag);
    repeat (IPG) tick();
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic reject(input string tag, input int idx);
    logic [2:0] ev;
    ev = 3'b000;
    ev[idx] = 1'b1;
    snap_fs = n_fs;
    tick();
    tick();
    chk({tag, "_err"}, err, 1'b1);
    chk({tag, "_done"}, done_vec, ev);
    chk({tag, "_nofs"}, fs, 1'b0);
    drop_req(idx);
    tick();
    chk({tag, "_err_once"}, err, 1'b0);
    repeat (IPG - 1) tick();
    chk({tag, "_idle"}, busy, 1'b0);
    chk({tag, "_fs_count"}, n_fs, snap_fs);
  endtask

  initial begin
    rst = 1'b1;
    hs_req = 1'b0; st_req = 1'b0; dt_req = 1'b0; dt_retry = 1'b0; tog_clr = 1'b0; fd = 1'b0;
    hs_type = 2'd0; st_type = 2'd0; dt_addr = 12'd0; dt_len = 12'd0;
    #1 rst = 1'b0;
    repeat (2) tick();
    chk("rst_fs", fs, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_btype", btype, 4'b0000);
    chk("rst_done", done_vec, 3'b000);
    chk("rst_err", err, 1'b0);
    chk("rst_txaddr", tx_addr, 12'd0);
    chk("rst_txlen", tx_len, 12'd0);
    rst = 1'b1;
    tick();
    chk("idle_busy", busy, 1'b0);

    // ACK, fd three cycles after fs
    hs_req = 1'b1; hs_type = 2'd1;
    serve("ack", 0, 4'b0001, 3, 3, 1'b0);
    drain("ack");

    // All three at once: ACK, DTYPE, DATA0 back to back through the gap
    hs_req = 1'b1; hs_type = 2'd1;
    st_req = 1'b1; st_type = 2'd1;
    dt_req = 1'b1; dt_addr = 12'h100; dt_len = 12'h040; dt_retry = 1'b0;
    serve("pri_hs", 0, 4'b0001, 2, 3, 1'b0);
    serve("pri_st", 1, 4'b1001, 2, 7, 1'b0);
    serve("pri_dt", 2, 4'b1101, 2, 7, 1'b0);
    drain("pri");

    // Toggle back to 0, then DATA0, DATA1, retry DATA1, then DATA0 proves tog ended 0
    tog_clr = 1'b1;
    tick();
    tog_clr = 1'b0;
    dt_req = 1'b1;
    serve("d0", 2, 4'b1101, 2, 3, 1'b0);
    drain("d0");
    dt_req = 1'b1;
    serve("d1", 2, 4'b1110, 2, 3, 1'b0);
    drain("d1");
    dt_req = 1'b1; dt_retry = 1'b1;
    serve("d_retry", 2, 4'b1110, 2, 3, 1'b0);
    dt_retry = 1'b0;
    drain("d_retry");
    dt_req = 1'b1;
    serve("d_after", 2, 4'b1101, 2, 3, 1'b0);
    drain("d_after");

    // tog is 1: send DATA1 (-> 0), DATA0 with clear at completion (stays 0), DATA0 again
    dt_req = 1'b1; dt_addr = 12'hABC; dt_len = 12'h007;
    serve("d_t1", 2, 4'b1110, 4, 3, 1'b0);
    drain("d_t1");
    dt_req = 1'b1;
    serve("d_clr", 2, 4'b1101, 2, 3, 1'b1);
    drain("d_clr");
    dt_req = 1'b1;
    serve("d_clr_chk", 2, 4'b1101, 2, 3, 1'b0);
    drain("d_clr_chk");

    // Rejects: zero length, illegal hs_type, illegal st_type
    dt_req = 1'b1; dt_len = 12'd0;
    snap_dt = n_dt;
    reject("rej_len0", 2);
    chk("rej_len0_dt_count", n_dt, snap_dt + 1);
    dt_len = 12'h040;
    hs_req = 1'b1; hs_type = 2'd0;
    reject("rej_hs", 0);
    st_req = 1'b1; st_type = 2'd3;
    reject("rej_st", 1);

    // fd already high in IDLE/LOAD/START is ignored; only BUSY consumes it
    fd = 1'b1; hs_req = 1'b1; hs_type = 2'd2;
    repeat (3) tick();
    chk("fdign_fs", fs, 1'b1);
    chk("fdign_nodone", done_vec, 3'b000);
    chk("fdign_btype", btype, 4'b0010);
    tick();
    chk("fdign_done", done_vec, 3'b001);
    fd = 1'b0; hs_req = 1'b0;
    tick();
    drain("fdign");

    // Request dropped mid-packet still completes
    st_req = 1'b1; st_type = 2'd2;
    wait_fs("drop", 3);
    st_req = 1'b0;
    chk("drop_btype", btype, 4'b1010);
    tick();
    fd = 1'b1;
    tick();
    chk("drop_done", done_vec, 3'b010);
    fd = 1'b0;
    tick();
    drain("drop");

    // Reset during BUSY (tog is 1 here), then resume: DATA0 shows tog was cleared
    dt_req = 1'b1;
    wait_fs("rstb", 3);
    chk("rstb_btype", btype, 4'b1110);
    snap_dt = n_dt;
    tick();
    #2 rst = 1'b0;
    #1;
    chk("rstb_fs", fs, 1'b0);
    chk("rstb_busy", busy, 1'b0);
    chk("rstb_done", done_vec, 3'b000);
    dt_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("rstb_dt_count", n_dt, snap_dt);
    dt_req = 1'b1;
    serve("resume", 2, 4'b1101, 2, 3, 1'b0);
    drain("resume");

`ifdef TYPEC_TX_SCHED_TIMEOUT_EN
    // fd never comes: fs drops after TMO BUSY cycles with err and done
    hs_req = 1'b1; hs_type = 2'd3;
    wait_fs("tmo", 3);
    n = 0;
    do begin
      tick();
      n++;
    end while (fs === 1'b1 && n < 40);
    chk("tmo_cycles", n, 8);
    chk("tmo_err", err, 1'b1);
    chk("tmo_done", done_vec, 3'b001);
    hs_req = 1'b0;
    tick();
    drain("tmo");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
